// File: rtl/c_v_seq_pkg.sv
// c_pkg: shared types and width helpers for the multi-beat unary-code validator
package c_pkg;
   typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_DRAIN, S_RESULT} state_t;
   typedef struct packed {
      logic admit;
      logic edge_seen;
      logic all_set;
      logic x_prev;
   } carry_t;
   function automatic int f_lw(input int pw, input int mb);
      return $clog2(pw * mb + 1);
   endfunction
   function automatic int f_cw(input int mb);
      return $clog2(mb + 1);
   endfunction
endpackage

// File: rtl/c_v_seq_beat.sv
// c_v_seq_beat: combinational evaluation of one beat as a chain of bit cells.
// Bits are normalised so the leading value is 1 and the terminal value is 0.
module c_v_seq_beat
   import c_pkg::*;
#(
   parameter int P_W = 8,
   parameter int P_IS_COMPLIMENT = 0,
   localparam int PW_W = (P_W > 1) ? $clog2(P_W) : 1
) (
   input  carry_t           i_c,
   input  logic             i_first,
   input  logic [P_W-1:0]   i_x,
   output carry_t           o_c,
   output logic             o_edge,
   output logic [PW_W-1:0]  o_pos,
   output logic             o_is_unary
);
   localparam logic INV = (P_IS_COMPLIMENT != 0);
   carry_t c;
   logic b, f, e;
   always_comb begin
      c = i_c;
      o_edge = 1'b0;
      o_pos = '0;
      b = 1'b0;
      f = 1'b0;
      e = 1'b0;
      for (int i = 0; i < P_W; i++) begin
         b = i_x[i] ^ INV;
         f = i_first && (i == 0);
         // a terminal first bit counts as an edge at index 0 (k=0)
         e = ~b & (f | c.x_prev);
         if (e && !o_edge) begin
            o_edge = 1'b1;
            o_pos = PW_W'(i);
         end
         c.admit = f | (c.admit & ~(b & ~c.x_prev));
         c.edge_seen = (c.edge_seen & ~f) | e;
         c.all_set = (c.all_set | f) & b;
         c.x_prev = b;
      end
      o_c = c;
      o_is_unary = c.admit & ~c.all_set;
   end
endmodule

// File: rtl/c_v_seq.sv
// c_v_seq: streams a bit-vector in P_W-bit beats and emits one registered
// unary-code verdict (is_unary, length, overflow) per vector.
module c_v_seq
   import c_pkg::*;
#(
   parameter int P_W = 8,
   parameter int P_MAX_BEATS = 16,
   parameter int P_IS_COMPLIMENT = 0,
   localparam int LW = f_lw(P_W, P_MAX_BEATS)
) (
   input  logic           i_clk,
   input  logic           i_rst,
   input  logic           i_in_vld,
   input  logic [P_W-1:0] i_in_x,
   input  logic           i_in_last,
   output logic           o_in_rdy,
   output logic           o_out_vld,
   input  logic           i_out_rdy,
   output logic           o_out_is_unary,
   output logic [LW-1:0]  o_out_len,
   output logic           o_out_ovf
);
   localparam int CW = f_cw(P_MAX_BEATS);
   localparam int PW_W = (P_W > 1) ? $clog2(P_W) : 1;
   state_t state_q, state_d;
   carry_t carry_q, carry_d, b_c;
   logic [CW-1:0] cnt_q, cnt_d, base;
   logic [LW-1:0] k_q, k_d, len_q, len_d;
   logic is_unary_q, is_unary_d, ovf_q, ovf_d;
   logic acc, first, b_edge, b_is_unary;
   logic [PW_W-1:0] b_pos;
   c_v_seq_beat #(.P_W(P_W), .P_IS_COMPLIMENT(P_IS_COMPLIMENT)) u_beat (
      .i_c(carry_q),
      .i_first(first),
      .i_x(i_in_x),
      .o_c(b_c),
      .o_edge(b_edge),
      .o_pos(b_pos),
      .o_is_unary(b_is_unary)
   );
   assign first = (state_q == S_IDLE);
   assign o_in_rdy = ~i_rst & (state_q != S_RESULT);
   assign acc = i_in_vld & o_in_rdy;
   assign base = first ? '0 : cnt_q;
   assign o_out_vld = (state_q == S_RESULT);
   assign o_out_is_unary = is_unary_q;
   assign o_out_len = len_q;
   assign o_out_ovf = ovf_q;
   always_comb begin
      state_d = state_q;
      carry_d = carry_q;
      cnt_d = cnt_q;
      k_d = k_q;
      is_unary_d = is_unary_q;
      len_d = len_q;
      ovf_d = ovf_q;
      if (acc && state_q == S_DRAIN) begin
         if (i_in_last) begin
            state_d = S_RESULT;
            is_unary_d = 1'b0;
            len_d = '0;
            ovf_d = 1'b1;
         end
      end else if (acc) begin
         carry_d = b_c;
         cnt_d = base + 1'b1;
         k_d = b_edge ? LW'(int'(base) * P_W + int'(b_pos)) : (first ? '0 : k_q);
         if (i_in_last) begin
            state_d = S_RESULT;
            is_unary_d = b_is_unary;
            len_d = b_is_unary ? k_d : '0;
            ovf_d = 1'b0;
         end else begin
            state_d = (cnt_d == CW'(P_MAX_BEATS)) ? S_DRAIN : S_ACCUM;
         end
      end
      if (state_q == S_RESULT && i_out_rdy) state_d = S_IDLE;
   end
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q <= S_IDLE;
         carry_q <= '0;
         cnt_q <= '0;
         k_q <= '0;
         is_unary_q <= 1'b0;
         len_q <= '0;
         ovf_q <= 1'b0;
      end else begin
         state_q <= state_d;
         carry_q <= carry_d;
         cnt_q <= cnt_d;
         k_q <= k_d;
         is_unary_q <= is_unary_d;
         len_q <= len_d;
         ovf_q <= ovf_d;
      end
   end
endmodule

// File: tb/tb_c_v_seq.sv
// tb_c_v_seq: directed vectors with hand-computed verdicts; instance 0 is the
// normal code, instance 1 the complemented code.
module tb_c_v_seq;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic [1:0] vld = '0, lst = '0, ordy = '0, rdy, ovld, isu, ovf;
   logic [3:0] xx [2];
   logic [4:0] len [2];
   int n_chk = 0, n_err = 0;
   always #5 clk = ~clk;
   c_v_seq #(.P_W(4), .P_MAX_BEATS(4), .P_IS_COMPLIMENT(0)) dut (
      .i_clk(clk), .i_rst(rst), .i_in_vld(vld[0]), .i_in_x(xx[0]), .i_in_last(lst[0]),
      .o_in_rdy(rdy[0]), .o_out_vld(ovld[0]), .i_out_rdy(ordy[0]),
      .o_out_is_unary(isu[0]), .o_out_len(len[0]), .o_out_ovf(ovf[0])
   );
   c_v_seq #(.P_W(4), .P_MAX_BEATS(4), .P_IS_COMPLIMENT(1)) dut_c (
      .i_clk(clk), .i_rst(rst), .i_in_vld(vld[1]), .i_in_x(xx[1]), .i_in_last(lst[1]),
      .o_in_rdy(rdy[1]), .o_out_vld(ovld[1]), .i_out_rdy(ordy[1]),
      .o_out_is_unary(isu[1]), .o_out_len(len[1]), .o_out_ovf(ovf[1])
   );
   task automatic chk(input string tag, input int act, input int exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, act, exp);
      end
   endtask
   task automatic send(input int d, input logic [3:0] x, input logic last);
      @(negedge clk);
      vld[d] = 1'b1;
      xx[d] = x;
      lst[d] = last;
      chk("in_rdy", int'(rdy[d]), 1);
      @(posedge clk);
      #1 vld[d] = 1'b0;
      lst[d] = 1'b0;
   endtask
   task automatic get(input int d, input string tag, input int e_u, input int e_len, input int e_ovf);
      @(negedge clk);
      chk({tag, ".vld"}, int'(ovld[d]), 1);
      chk({tag, ".is_unary"}, int'(isu[d]), e_u);
      chk({tag, ".len"}, int'(len[d]), e_len);
      chk({tag, ".ovf"}, int'(ovf[d]), e_ovf);
      chk({tag, ".rdy_low"}, int'(rdy[d]), 0);
      ordy[d] = 1'b1;
      @(posedge clk);
      #1 ordy[d] = 1'b0;
      @(negedge clk);
      chk({tag, ".vld_drop"}, int'(ovld[d]), 0);
   endtask
   initial begin
      xx[0] = '0;
      xx[1] = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         chk("rst.in_rdy", int'(rdy[d]), 0);
         chk("rst.vld", int'(ovld[d]), 0);
         chk("rst.is_unary", int'(isu[d]), 0);
         chk("rst.len", int'(len[d]), 0);
         chk("rst.ovf", int'(ovf[d]), 0);
      end
      rst = 1'b0;
      send(0, 4'b0111, 1); get(0, "t1", 1, 3, 0);
      send(0, 4'b1111, 0); send(0, 4'b0000, 1); get(0, "t2", 1, 4, 0);
      send(0, 4'b1111, 0); send(0, 4'b0001, 1); get(0, "t3a", 1, 5, 0);
      send(0, 4'b1111, 0); send(0, 4'b1111, 1); get(0, "t3b", 0, 0, 0);
      send(0, 4'b0101, 1); get(0, "t4a", 0, 0, 0);
      send(0, 4'b0000, 0); send(0, 4'b0000, 1); get(0, "t4b", 1, 0, 0);
      send(0, 4'b0010, 1); get(0, "t4c", 0, 0, 0);
      send(0, 4'b1111, 0); send(0, 4'b1111, 0); send(0, 4'b1111, 1); get(0, "t3c", 0, 0, 0);
      send(0, 4'b0111, 0); send(0, 4'b0000, 0); send(0, 4'b0000, 0); send(0, 4'b0000, 1);
      get(0, "full", 1, 3, 0);
      for (int i = 0; i < 6; i++) send(0, 4'b1111, i == 5);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("hold.vld", int'(ovld[0]), 1);
         chk("hold.ovf", int'(ovf[0]), 1);
         chk("hold.is_unary", int'(isu[0]), 0);
         chk("hold.len", int'(len[0]), 0);
         chk("hold.in_rdy", int'(rdy[0]), 0);
      end
      get(0, "t5", 0, 0, 1);
      send(0, 4'b1111, 0); send(0, 4'b1111, 0);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("t6.vld_after_rst", int'(ovld[0]), 0);
      send(0, 4'b0011, 1); get(0, "t6", 1, 2, 0);
      send(0, 4'b0111, 1); get(0, "t6.rst_mid_result_pre", 1, 3, 0);
      send(0, 4'b0001, 1);
      @(negedge clk);
      chk("t6.result_pending", int'(ovld[0]), 1);
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("t6.result_dropped", int'(ovld[0]), 0);
      send(1, 4'b1000, 1); get(1, "c1", 1, 3, 0);
      send(1, 4'b1010, 1); get(1, "c4a", 0, 0, 0);
      send(1, 4'b1111, 0); send(1, 4'b1111, 1); get(1, "c4b", 1, 0, 0);
      send(1, 4'b1101, 1); get(1, "c4c", 0, 0, 0);
      send(1, 4'b0000, 0); send(1, 4'b1110, 1); get(1, "c3a", 1, 5, 0);
      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule
